// File: rtl/msk_timing_pkg.sv
// Shared types and fixed-point helpers for the MSK symbol-timing NCO.
package msk_timing_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    localparam int unsigned CNT_W = 16;

    // n samples expressed in phase units (ONE = 2**frac_w)
    function automatic logic [63:0] samples(input int unsigned n, input int unsigned frac_w);
        return 64'(n) << frac_w;
    endfunction

    function automatic logic [63:0] one(input int unsigned frac_w);
        return samples(1, frac_w);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b,
        input logic [CNT_W-1:0] lim
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/msk_lock_det.sv
// Timing-lock detector: counts consecutive small/large loop-filter outputs at symbol strobes.
module msk_lock_det
    import msk_timing_pkg::*;
#(
    parameter int unsigned CTRL_W     = 18,
    parameter int unsigned LOCK_THR   = 2048,
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned UNLOCK_CNT = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     strobe,
    input  logic                     clear,
    input  logic signed [CTRL_W-1:0] ctrl,
    output logic                     locked
);

    localparam logic signed [CTRL_W-1:0] CTRL_MIN  = {1'b1, {(CTRL_W-1){1'b0}}};
    localparam logic [CTRL_W-1:0]        CTRL_MAXU = {1'b0, {(CTRL_W-1){1'b1}}};
    localparam logic [CTRL_W:0]          THR       = (CTRL_W+1)'(LOCK_THR);
    localparam logic [CNT_W-1:0]         GOOD_MAX  = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]         BAD_MAX   = CNT_W'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0]         STEP      = CNT_W'(1);

    lock_state_t       state;
    logic [CNT_W-1:0]  good_cnt;
    logic [CNT_W-1:0]  bad_cnt;
    logic [CTRL_W-1:0] mag;
    logic              good_hit;

    // most-negative input has no positive counterpart; clamp its magnitude
    always_comb begin
        if (ctrl == CTRL_MIN)
            mag = CTRL_MAXU;
        else if (ctrl[CTRL_W-1])
            mag = unsigned'(-ctrl);
        else
            mag = unsigned'(ctrl);
    end

    assign good_hit = ({1'b0, mag} < THR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
        end else if (clear) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
        end else if (strobe) begin
            if (good_hit) begin
                good_cnt <= sat_add(good_cnt, STEP, GOOD_MAX);
                bad_cnt  <= '0;
                if (state == UNLOCKED && sat_add(good_cnt, STEP, GOOD_MAX) >= GOOD_MAX) begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                end
            end else begin
                bad_cnt  <= sat_add(bad_cnt, STEP, BAD_MAX);
                good_cnt <= '0;
                if (state == LOCKED && sat_add(bad_cnt, STEP, BAD_MAX) >= BAD_MAX) begin
                    state  <= UNLOCKED;
                    locked <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/msk_timing_nco.sv
// MSK symbol-timing NCO: modulo-OSF phase accumulator with symbol/mid-symbol strobes and lock flag.
module msk_timing_nco
    import msk_timing_pkg::*;
#(
    parameter int unsigned OSF        = 20,
    parameter int unsigned CTRL_W     = 18,
    parameter int unsigned INT_W      = 5,
    parameter int unsigned FRAC_W     = 27,
    parameter int unsigned CTRL_SHIFT = FRAC_W - CTRL_W,
    parameter int unsigned LOCK_THR   = 2048,
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned UNLOCK_CNT = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      samp_en_i,
    input  logic                      ctrl_en_i,
    input  logic signed [CTRL_W-1:0]  ctrl_i,
    input  logic                      load_i,
    input  logic [INT_W+FRAC_W-1:0]   load_phase_i,
    output logic                      sym_valid_o,
    output logic                      mid_valid_o,
    output logic [INT_W-1:0]          phase_int_o,
    output logic [FRAC_W-1:0]         mu_o,
    output logic                      locked_o
);

    localparam int unsigned PW = INT_W + FRAC_W;
    localparam int unsigned SW = PW + 2;

    if ((2**INT_W) < OSF || (CTRL_SHIFT + CTRL_W) > (FRAC_W + 1)) begin : g_param_check
        $error("msk_timing_nco: illegal OSF/INT_W or CTRL_SHIFT/CTRL_W/FRAC_W combination");
    end

    localparam logic [63:0] ONE64  = one(FRAC_W);
    localparam logic [63:0] MOD64  = samples(OSF, FRAC_W);
    localparam logic [63:0] HALF64 = samples(OSF / 2, FRAC_W);

    localparam logic signed [SW-1:0] ONE_S   = signed'(ONE64[SW-1:0]);
    localparam logic signed [SW-1:0] INC_MIN = signed'(ONE64[SW:1]);
    localparam logic signed [SW-1:0] INC_MAX = ONE_S + INC_MIN;
    localparam logic [SW-1:0]        MODV    = MOD64[SW-1:0];
    localparam logic [SW-1:0]        HALF    = HALF64[SW-1:0];

    logic [PW-1:0]          phase;
    logic signed [SW-1:0]   ctrl_ext;
    logic signed [SW-1:0]   ctrl_term;
    logic signed [SW-1:0]   inc_raw;
    logic signed [SW-1:0]   inc;
    logic [SW-1:0]          phase_ext;
    logic [SW-1:0]          sum;
    logic                   wrap;
    logic                   mid_hit;

    always_comb begin
        ctrl_ext  = {{(SW-CTRL_W){ctrl_i[CTRL_W-1]}}, ctrl_i};
        ctrl_term = '0;
        if (ctrl_en_i)
            ctrl_term = ctrl_ext <<< CTRL_SHIFT;
        inc_raw = ONE_S + ctrl_term;
        // clamp to [0.5, 1.5] samples so a single sample never wraps twice
        if (inc_raw < INC_MIN)
            inc = INC_MIN;
        else if (inc_raw > INC_MAX)
            inc = INC_MAX;
        else
            inc = inc_raw;
        phase_ext = {2'b00, phase};
        sum       = phase_ext + unsigned'(inc);
        wrap      = (sum >= MODV);
        mid_hit   = !wrap && (phase_ext < HALF) && (sum >= HALF);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= '0;
            sym_valid_o <= 1'b0;
            mid_valid_o <= 1'b0;
        end else if (load_i) begin
            phase       <= PW'({2'b00, load_phase_i} % MODV);
            sym_valid_o <= 1'b0;
            mid_valid_o <= 1'b0;
        end else if (samp_en_i) begin
            phase       <= wrap ? PW'(sum - MODV) : PW'(sum);
            sym_valid_o <= wrap;
            mid_valid_o <= mid_hit;
        end else begin
            sym_valid_o <= 1'b0;
            mid_valid_o <= 1'b0;
        end
    end

    assign phase_int_o = phase[PW-1:FRAC_W];
    assign mu_o        = phase[FRAC_W-1:0];

    msk_lock_det #(
        .CTRL_W     (CTRL_W),
        .LOCK_THR   (LOCK_THR),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock_det (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (sym_valid_o),
        .clear   (load_i | ~ctrl_en_i),
        .ctrl    (ctrl_i),
        .locked  (locked_o)
    );

endmodule

// File: tb/tb_msk_timing_nco.sv
// Directed bench for msk_timing_nco; a second instance with a wider shift exercises increment clamping.
module tb_msk_timing_nco;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               samp_en = 1'b0, ctrl_en = 1'b0, load = 1'b0;
    logic signed [17:0] ctrl = '0;
    logic [31:0]        load_phase = '0;
    logic               sym, mid, locked;
    logic [4:0]         pint;
    logic [26:0]        mu;

    logic               samp_en2 = 1'b0, ctrl_en2 = 1'b0, load2 = 1'b0;
    logic signed [15:0] ctrl2 = '0;
    logic [31:0]        load_phase2 = '0;
    logic               sym2, mid2, locked2;
    logic [4:0]         pint2;
    logic [26:0]        mu2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msk_timing_nco dut (
        .clk(clk), .reset_n(reset_n), .samp_en_i(samp_en), .ctrl_en_i(ctrl_en),
        .ctrl_i(ctrl), .load_i(load), .load_phase_i(load_phase),
        .sym_valid_o(sym), .mid_valid_o(mid), .phase_int_o(pint), .mu_o(mu),
        .locked_o(locked)
    );

    msk_timing_nco #(.CTRL_W(16), .CTRL_SHIFT(12)) dut_clamp (
        .clk(clk), .reset_n(reset_n), .samp_en_i(samp_en2), .ctrl_en_i(ctrl_en2),
        .ctrl_i(ctrl2), .load_i(load2), .load_phase_i(load_phase2),
        .sym_valid_o(sym2), .mid_valid_o(mid2), .phase_int_o(pint2), .mu_o(mu2),
        .locked_o(locked2)
    );

    task automatic wait_sym(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (sym) begin n = i; return; end
        end
    endtask

    task automatic wait_sym2(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (sym2) begin n = i; return; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (sym !== 1'b0) begin errors++; $display("FAIL reset_sym got %b exp 0", sym); end
        checks++; if (mid !== 1'b0) begin errors++; $display("FAIL reset_mid got %b exp 0", mid); end
        checks++; if (pint !== 5'd0) begin errors++; $display("FAIL reset_pint got %0d exp 0", pint); end
        checks++; if (mu !== 27'd0) begin errors++; $display("FAIL reset_mu got %0d exp 0", mu); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
        checks++; if ({sym2, mid2, locked2, pint2, mu2} !== '0) begin errors++; $display("FAIL reset_dut2 outputs not zero"); end
        samp_en = 1'b1; ctrl_en = 1'b1; ctrl = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_free_run();
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            checks++; if (sym !== (c % 20 == 0)) begin errors++; $display("FAIL free_sym c=%0d got %b exp %b", c, sym, (c % 20 == 0)); end
            checks++; if (mid !== (c % 20 == 10)) begin errors++; $display("FAIL free_mid c=%0d got %b exp %b", c, mid, (c % 20 == 10)); end
            checks++; if (pint !== 5'(c % 20)) begin errors++; $display("FAIL free_pint c=%0d got %0d exp %0d", c, pint, c % 20); end
            checks++; if (mu !== 27'd0) begin errors++; $display("FAIL free_mu c=%0d got %0d exp 0", c, mu); end
        end
    endtask

    task automatic test_speed();
        int n;
        ctrl = 18'sh10000;
        for (int k = 0; k < 2; k++) begin
            wait_sym(n);
            checks++; if (n !== 16) begin errors++; $display("FAIL speed_up_period got %0d exp 16", n); end
        end
        ctrl = 18'sh20000;
        wait_sym(n);
        checks++; if (n !== 40) begin errors++; $display("FAIL slow_down_period got %0d exp 40", n); end
        ctrl = '0;
    endtask

    task automatic test_gating();
        int got = -1;
        samp_en = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 5) begin
                checks++; if (pint !== 5'd2) begin errors++; $display("FAIL gate_hold_pint got %0d exp 2", pint); end
            end
            if (c == 20) begin
                checks++; if (mid !== 1'b1) begin errors++; $display("FAIL gate_mid got %b exp 1", mid); end
            end
            if (c == 21) begin
                checks++; if (mid !== 1'b0) begin errors++; $display("FAIL gate_mid_off got %b exp 0", mid); end
            end
            if (sym) begin got = c; break; end
            samp_en = ~samp_en;
        end
        checks++; if (got !== 40) begin errors++; $display("FAIL gate_period got %0d exp 40", got); end
        samp_en = 1'b1;
    endtask

    task automatic test_load();
        repeat (19) @(negedge clk);
        checks++; if (pint !== 5'd19) begin errors++; $display("FAIL load_pre_pint got %0d exp 19", pint); end
        load = 1'b1; load_phase = 32'd2617245696;
        @(negedge clk);
        load = 1'b0;
        checks++; if (sym !== 1'b0) begin errors++; $display("FAIL load_no_strobe got %b exp 0", sym); end
        checks++; if (pint !== 5'd19 || mu !== 27'd67108864) begin errors++; $display("FAIL load_phase got %0d/%0d exp 19/67108864", pint, mu); end
        @(negedge clk);
        checks++; if (sym !== 1'b1) begin errors++; $display("FAIL load_next_sym got %b exp 1", sym); end
        checks++; if (pint !== 5'd0 || mu !== 27'd67108864) begin errors++; $display("FAIL load_wrap_phase got %0d/%0d exp 0/67108864", pint, mu); end
        samp_en = 1'b0; load = 1'b1; load_phase = 32'hFFFF_FFFF;
        @(negedge clk);
        load = 1'b0;
        checks++; if (pint !== 5'd11 || mu !== 27'd134217727) begin errors++; $display("FAIL load_mod got %0d/%0d exp 11/134217727", pint, mu); end
        checks++; if (sym !== 1'b0) begin errors++; $display("FAIL load_mod_sym got %b exp 0", sym); end
        load = 1'b1; load_phase = '0;
        @(negedge clk);
        load = 1'b0; samp_en = 1'b1;
    endtask

    task automatic test_lock();
        int n, k;
        logic early;
        wait_sym(n);
        ctrl_en = 1'b0; ctrl = 18'sd100;
        @(negedge clk);
        ctrl_en = 1'b1;
        k = 0; early = 1'b0;
        for (int c = 0; c < 1000 && k < 32; c++) begin
            @(negedge clk);
            if (locked) early = 1'b1;
            if (sym) k++;
        end
        checks++; if (k !== 32) begin errors++; $display("FAIL lock_strobes got %0d exp 32", k); end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL lock_early got %b exp 0", early); end
        @(negedge clk);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise got %b exp 1", locked); end
        ctrl = 18'sd5000;
        k = 0; early = 1'b0;
        for (int c = 0; c < 400 && k < 8; c++) begin
            @(negedge clk);
            if (!locked) early = 1'b1;
            if (sym) k++;
        end
        checks++; if (k !== 8 || early !== 1'b0) begin errors++; $display("FAIL unlock_hold got %0d/%b exp 8/0", k, early); end
        @(negedge clk);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL unlock_fall got %b exp 0", locked); end
        ctrl = 18'sd100;
        k = 0;
        for (int c = 0; c < 1000 && k < 32; c++) begin
            @(negedge clk);
            if (sym) k++;
        end
        @(negedge clk);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got %b exp 1", locked); end
        ctrl_en = 1'b0;
        @(negedge clk);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ctrl_en_unlock got %b exp 0", locked); end
        ctrl_en = 1'b1; ctrl = '0;
    endtask

    task automatic test_reset_mid();
        int n;
        load = 1'b1; load_phase = 32'd979795558;
        @(negedge clk);
        load = 1'b0;
        checks++; if (pint !== 5'd7) begin errors++; $display("FAIL rmid_pre_pint got %0d exp 7", pint); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({sym, mid, locked} !== 3'b000) begin errors++; $display("FAIL rmid_strobes got %b exp 000", {sym, mid, locked}); end
        checks++; if (pint !== 5'd0 || mu !== 27'd0) begin errors++; $display("FAIL rmid_phase got %0d/%0d exp 0/0", pint, mu); end
        @(negedge clk);
        checks++; if (pint !== 5'd0) begin errors++; $display("FAIL rmid_hold got %0d exp 0", pint); end
        reset_n = 1'b1;
        wait_sym(n);
        checks++; if (n !== 20) begin errors++; $display("FAIL rmid_first_sym got %0d exp 20", n); end
    endtask

    task automatic test_clamp();
        int n;
        samp_en2 = 1'b1; ctrl_en2 = 1'b1; ctrl2 = 16'sh7FFF;
        wait_sym2(n);
        checks++; if (n !== 14) begin errors++; $display("FAIL clamp_p1 got %0d exp 14", n); end
        checks++; if (pint2 !== 5'd1 || mu2 !== 27'd0) begin errors++; $display("FAIL clamp_ph1 got %0d/%0d exp 1/0", pint2, mu2); end
        wait_sym2(n);
        checks++; if (n !== 13) begin errors++; $display("FAIL clamp_p2 got %0d exp 13", n); end
        checks++; if (pint2 !== 5'd0 || mu2 !== 27'd67108864) begin errors++; $display("FAIL clamp_ph2 got %0d/%0d exp 0/67108864", pint2, mu2); end
        wait_sym2(n);
        checks++; if (n !== 13) begin errors++; $display("FAIL clamp_p3 got %0d exp 13", n); end
        checks++; if (pint2 !== 5'd0 || mu2 !== 27'd0) begin errors++; $display("FAIL clamp_ph3 got %0d/%0d exp 0/0", pint2, mu2); end
        ctrl2 = 16'sh8000;
        wait_sym2(n);
        checks++; if (n !== 40) begin errors++; $display("FAIL clamp_min_period got %0d exp 40", n); end
        samp_en2 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_speed();
        test_gating();
        test_load();
        test_lock();
        test_reset_mid();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
